// File: rtl/alu_mdu_controller.sv
// ALU operation decoder plus iterative RV-M multiply/divide unit for EX.
// Ports: clk, rst_n, ALUOp/Funct7/Funct3/is_rtype -> Operation; in_valid/in_ready,
// op_a/op_b accept M-ops; out_valid/out_ready/mdu_result return them; flush aborts;
// mdu_stall freezes IF/ID/EX while an M-op is pending.
module alu_mdu_controller #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            is_rtype,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic [3:0]      Operation,
    output logic            mdu_stall,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] mdu_result
);
    localparam int CW = $clog2(XLEN + 2);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt;
    logic [XLEN-1:0]     a_reg, b_reg, res;
    logic [2:0]          f3_reg;
    logic                neg_a, neg_b;
    logic [2*XLEN-1:0]   p;

    logic m_op, accept;
    assign m_op   = ENABLE_M && (ALUOp == 2'b10) && is_rtype && (Funct7 == 7'b0000001);
    assign accept = in_valid && (state == S_IDLE) && m_op && !flush;

    always_comb begin
        Operation = 4'b0000;
        case (ALUOp)
            2'b00: Operation = 4'b0010;
            2'b01: Operation = 4'b1000;
            2'b11: Operation = 4'b0000;
            default: begin
                if (!m_op) begin
                    case (Funct3)
                        3'b000: Operation = (is_rtype && Funct7[5]) ? 4'b0110 : 4'b0010;
                        3'b001: Operation = 4'b0100;
                        3'b010: Operation = 4'b1100;
                        3'b100: Operation = 4'b0011;
                        3'b101: Operation = Funct7[5] ? 4'b0111 : 4'b0101;
                        3'b110: Operation = 4'b0001;
                        default: Operation = 4'b0000;
                    endcase
                end
            end
        endcase
    end

    // Operand signedness: MULH s*s, MULHSU s*u, MULHU u*u; DIV/REM signed, DIVU/REMU not.
    logic            sign_a, sign_b, na, nb;
    logic [XLEN-1:0] mag_a, mag_b;
    assign sign_a = f3_reg[2] ? ~f3_reg[0] : (f3_reg[1:0] != 2'b11);
    assign sign_b = f3_reg[2] ? ~f3_reg[0] : ~f3_reg[1];
    assign na     = sign_a & a_reg[XLEN-1];
    assign nb     = sign_b & b_reg[XLEN-1];
    assign mag_a  = na ? (0 - a_reg) : a_reg;
    assign mag_b  = nb ? (0 - b_reg) : b_reg;

    // p holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    logic [XLEN:0]     msum, trial;
    logic [2*XLEN-1:0] mul_next, div_next;
    assign msum     = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, b_reg} : '0);
    assign mul_next = {msum, p[XLEN-1:1]};
    assign trial    = {p[2*XLEN-1:XLEN], p[XLEN-1]} - {1'b0, b_reg};
    assign div_next = trial[XLEN] ? {p[2*XLEN-2:0], 1'b0}
                                  : {trial[XLEN-1:0], p[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q_out, r_out, fix_val;
    assign prod  = (neg_a ^ neg_b) ? (0 - p) : p;
    assign q_out = ((neg_a ^ neg_b) && (b_reg != '0)) ? (0 - p[XLEN-1:0]) : p[XLEN-1:0];
    assign r_out = neg_a ? (0 - p[2*XLEN-1:XLEN]) : p[2*XLEN-1:XLEN];
    assign fix_val = f3_reg[2] ? (f3_reg[1] ? r_out : q_out)
                               : ((f3_reg[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:        if (accept) state_n = Funct3[2] ? S_DIV : S_MUL;
                S_MUL, S_DIV:  if (cnt == CW'(XLEN)) state_n = S_FIX;
                S_FIX:         state_n = S_DONE;
                S_DONE:        if (out_ready) state_n = S_IDLE;
                default:       state_n = S_IDLE;
            endcase
        end
    end

    // cnt 0 is a setup cycle taking magnitudes; cnt 1..XLEN are the iterations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            f3_reg <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            p      <= '0;
            res    <= '0;
        end else if (flush) begin
            cnt <= '0;
            res <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    res <= '0;
                    if (accept) begin
                        a_reg  <= op_a;
                        b_reg  <= op_b;
                        f3_reg <= Funct3;
                        cnt    <= '0;
                    end
                end
                S_MUL, S_DIV: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == '0) begin
                        neg_a <= na;
                        neg_b <= nb;
                        p     <= {{XLEN{1'b0}}, mag_a};
                        b_reg <= mag_b;
                    end else if (state == S_MUL) begin
                        p <= mul_next;
                    end else begin
                        p <= div_next;
                    end
                end
                S_FIX:  res <= fix_val;
                S_DONE: begin
                    if (out_ready) begin
                        res <= '0;
                        cnt <= '0;
                    end
                end
                default: res <= '0;
            endcase
        end
    end

    assign in_ready   = (state == S_IDLE);
    assign out_valid  = (state == S_DONE) && !flush;
    assign mdu_result = res;
    assign mdu_stall  = ((state == S_IDLE) && in_valid && m_op) || (state == S_MUL)
                      || (state == S_DIV) || (state == S_FIX)
                      || ((state == S_DONE) && !out_ready);
endmodule

// File: tb/tb_alu_mdu_controller.sv
// Directed testbench for alu_mdu_controller (XLEN 32).
// Covers decode table, MUL/DIV results, latency, hold, flush and reset.
module tb_alu_mdu_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ALUOp;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic        is_rtype;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a, op_b;
    logic        flush;
    logic [3:0]  Operation;
    logic        mdu_stall;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mdu_result;

    int vectors = 0;
    int miscompares = 0;

    alu_mdu_controller #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .is_rtype(is_rtype), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .flush(flush), .Operation(Operation),
        .mdu_stall(mdu_stall), .out_valid(out_valid), .out_ready(out_ready),
        .mdu_result(mdu_result)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        ALUOp = 2'b10; is_rtype = 1'b1; Funct7 = 7'b0000001;
        Funct3 = f3; op_a = a; op_b = b;
    endtask

    task automatic dec(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic rt, input logic [3:0] exp, input string nm);
        ALUOp = aop; Funct7 = f7; Funct3 = f3; is_rtype = rt;
        #1;
        vectors++;
        if (Operation !== exp) begin
            miscompares++;
            $display("FAIL dec_%s: got %b want %b", nm, Operation, exp);
        end
    endtask

    // Full M-op with out_ready high: checks acceptance, latency, result, return to IDLE.
    task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string nm);
        int lat;
        set_mop(f3, a, b);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || mdu_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_accept: ready=%b stall=%b want 1 1", nm, in_ready, mdu_stall);
        end
        tick;
        in_valid = 1'b0; op_a = ~a; op_b = ~b;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat != 34) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d want 34", nm, lat);
        end
        vectors++;
        if (mdu_result !== exp) begin
            miscompares++;
            $display("FAIL %s_result: got %h want %h", nm, mdu_result, exp);
        end
        tick;
        vectors++;
        if (out_valid !== 1'b0 || mdu_result !== 32'h0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_idle: valid=%b res=%h ready=%b want 0 0 1",
                     nm, out_valid, mdu_result, in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        ALUOp = 2'b00; Funct7 = 7'h0; Funct3 = 3'h0; is_rtype = 1'b0;
        op_a = '0; op_b = '0;
        #12;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mdu_result !== 32'h0 || mdu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: ready=%b valid=%b res=%h stall=%b want 1 0 0 0",
                     in_ready, out_valid, mdu_result, mdu_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_decode;
        dec(2'b00, 7'h00, 3'b010, 1'b0, 4'b0010, "lw");
        dec(2'b01, 7'h00, 3'b000, 1'b0, 4'b1000, "beq");
        dec(2'b11, 7'h00, 3'b000, 1'b0, 4'b0000, "jal");
        dec(2'b10, 7'h00, 3'b000, 1'b1, 4'b0010, "add");
        dec(2'b10, 7'h20, 3'b000, 1'b1, 4'b0110, "sub");
        dec(2'b10, 7'h20, 3'b000, 1'b0, 4'b0010, "addi");
        dec(2'b10, 7'h00, 3'b001, 1'b1, 4'b0100, "sll");
        dec(2'b10, 7'h00, 3'b010, 1'b1, 4'b1100, "slt");
        dec(2'b10, 7'h00, 3'b011, 1'b1, 4'b0000, "sltu");
        dec(2'b10, 7'h00, 3'b100, 1'b1, 4'b0011, "xor");
        dec(2'b10, 7'h00, 3'b101, 1'b1, 4'b0101, "srl");
        dec(2'b10, 7'h20, 3'b101, 1'b1, 4'b0111, "sra");
        dec(2'b10, 7'h00, 3'b110, 1'b1, 4'b0001, "or");
        dec(2'b10, 7'h00, 3'b111, 1'b1, 4'b0000, "and");
        dec(2'b10, 7'h01, 3'b000, 1'b1, 4'b0000, "mul");
        dec(2'b10, 7'h01, 3'b110, 1'b1, 4'b0000, "rem");
        dec(2'b10, 7'h01, 3'b000, 1'b0, 4'b0010, "addi_f7");
        dec(2'b10, 7'h01, 3'b110, 1'b0, 4'b0001, "ori_f7");
    endtask

    task automatic test_base_no_stall;
        ALUOp = 2'b10; Funct7 = 7'h20; Funct3 = 3'b000; is_rtype = 1'b1;
        in_valid = 1'b1;
        #1;
        vectors++;
        if (mdu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL base_stall: got %b want 0", mdu_stall);
        end
        tick;
        vectors++;
        if (in_ready !== 1'b1 || mdu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL base_idle: ready=%b stall=%b want 1 0", in_ready, mdu_stall);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mul;
        run_mop(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        run_mop(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        run_mop(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1");
        run_mop(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        run_mop(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    endtask

    task automatic test_div;
        run_mop(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
        run_mop(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
        run_mop(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_nb");
        run_mop(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem_nb");
        run_mop(3'b101, 32'd100, 32'd7, 32'd14, "divu");
        run_mop(3'b111, 32'd100, 32'd7, 32'd2, "remu");
        run_mop(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu0");
        run_mop(3'b110, 32'd5, 32'd0, 32'd5, "rem0");
        run_mop(3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, "div0_neg");
        run_mop(3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "rem0_neg");
    endtask

    task automatic test_overflow;
        run_mop(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_mop(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
    endtask

    task automatic test_hold;
        int lat;
        set_mop(3'b000, 32'd7, 32'hFFFF_FFFD);
        in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat != 34) begin
            miscompares++;
            $display("FAIL hold_latency: got %0d want 34", lat);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || mdu_result !== 32'hFFFF_FFEB || mdu_stall !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_%0d: valid=%b res=%h stall=%b want 1 ffffffeb 1",
                         i, out_valid, mdu_result, mdu_stall);
            end
            tick;
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (mdu_stall !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: stall=%b valid=%b want 0 1", mdu_stall, out_valid);
        end
        tick;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mdu_result !== 32'h0) begin
            miscompares++;
            $display("FAIL hold_idle: valid=%b ready=%b res=%h want 0 1 0",
                     out_valid, in_ready, mdu_result);
        end
    endtask

    task automatic test_flush;
        int lat;
        set_mop(3'b100, 32'hFFFF_FFF9, 32'd2);
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (10) tick;
        flush = 1'b1; in_valid = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_busy: valid=%b ready=%b want 0 0", out_valid, in_ready);
        end
        tick;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mdu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: ready=%b valid=%b stall=%b want 1 0 0",
                     in_ready, out_valid, mdu_stall);
        end
        flush = 1'b1; in_valid = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_noaccept: ready=%b want 1", in_ready);
        end
        in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat != 34) begin
            miscompares++;
            $display("FAIL flush_done_latency: got %0d want 34", lat);
        end
        flush = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_done_valid: got %b want 0", out_valid);
        end
        tick;
        flush = 1'b0; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || mdu_result !== 32'h0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_done_idle: ready=%b res=%h valid=%b want 1 0 0",
                     in_ready, mdu_result, out_valid);
        end
        run_mop(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "post_flush");
    endtask

    task automatic test_reset_mid;
        set_mop(3'b100, 32'd100, 32'd7);
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (5) tick;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mdu_result !== 32'h0 || mdu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: ready=%b valid=%b res=%h stall=%b want 1 0 0 0",
                     in_ready, out_valid, mdu_result, mdu_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        run_mop(3'b101, 32'd100, 32'd7, 32'd14, "post_reset");
    endtask

    task automatic test_back_to_back;
        run_mop(3'b000, 32'd12345, 32'd678, 32'd8369910, "b2b_mul");
        run_mop(3'b111, 32'd12345, 32'd678, 32'd141, "b2b_remu");
    endtask

    initial begin
        test_reset;
        test_decode;
        test_base_no_stall;
        test_mul;
        test_div;
        test_overflow;
        test_hold;
        test_flush;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
